segment_capture: RTL and testbench

//  Receive-side decoder for the clock's multiplexed 4-digit 7-segment scan bus.

---
 rtl/segment_capture_if.sv | 24 ++
 rtl/segment_capture.sv | 192 +++++++++++++++++++
 tb/tb_segment_capture.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/segment_capture_if.sv
// Scan-bus observation port plus decoded result for segment_capture.
// Latency: none, signal bundle only.
// Backpressure: none, the scan bus is free-running and results are unacknowledged.
interface segment_capture_if;
  logic [3:0]  bytee_in;
  logic [6:0]  segment_in;
  logic [11:0] data_out;
  logic        data_valid;
  logic        data_stable;
  logic        err_pattern;
  logic        err_timeout;

  // Display driver / stimulus side.
  modport master (
    output bytee_in, segment_in,
    input  data_out, data_valid, data_stable, err_pattern, err_timeout
  );

  // Decoder side.
  modport slave (
    input  bytee_in, segment_in,
    output data_out, data_valid, data_stable, err_pattern, err_timeout
  );
endinterface

// File: rtl/segment_capture.sv
// Decodes a multiplexed 4-digit 7-segment scan back to a packed {high,low} value.
// Latency: last digit at pins -> data_valid after 3 cycles (input reg, CHECK, output reg).
// Backpressure: none; a digit landing in the input register during CHECK is held one cycle.
module segment_capture #(
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input logic         clock,
  input logic         reset,
  segment_capture_if.slave bus
);

  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TCNT_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       bytee_q;
  logic [6:0]       seg_q;
  logic [3:0][3:0]  slot_q;
  logic [3:0]       seen_q;
  logic [MW-1:0]    match_q;
  logic [TW-1:0]    tcnt_q;
  logic [11:0]      last_q;
  logic [11:0]      data_out_q;
  logic             data_valid_q;
  logic             data_stable_q;
  logic             err_pattern_q;
  logic             err_timeout_q;

  logic [6:0]       seg_lvl;
  logic             glyph_ok;
  logic [3:0]       glyph_digit;
  logic             onehot;
  logic [1:0]       slot_idx;
  logic [3:0]       seen_set;
  logic [6:0]       low_val;
  logic [6:0]       high_val;
  logic [11:0]      frame_val;
  logic             frame_bad;
  logic             frame_eq;
  logic [MW-1:0]    match_inc;
  logic [MW-1:0]    match_new;
  logic             publish;
  logic [TW-1:0]    tcnt_inc;
  logic             timeout_hit;

  assign seg_lvl = SEG_ACTIVE_LOW ? ~seg_q : seg_q;

  // Glyph lookup: anything outside the ten digit patterns is illegal.
  always_comb begin
    glyph_ok    = 1'b1;
    glyph_digit = 4'd0;
    case (seg_lvl)
      7'h3F: glyph_digit = 4'd0;
      7'h06: glyph_digit = 4'd1;
      7'h5B: glyph_digit = 4'd2;
      7'h4F: glyph_digit = 4'd3;
      7'h66: glyph_digit = 4'd4;
      7'h6D: glyph_digit = 4'd5;
      7'h7D: glyph_digit = 4'd6;
      7'h07: glyph_digit = 4'd7;
      7'h7F: glyph_digit = 4'd8;
      7'h6F: glyph_digit = 4'd9;
      default: glyph_ok = 1'b0;
    endcase
  end

  assign onehot   = (bytee_q != 4'd0) && ((bytee_q & (bytee_q - 4'd1)) == 4'd0);
  assign seen_set = seen_q | bytee_q;

  // Slot index of the active enable; only meaningful when onehot is true.
  always_comb begin
    slot_idx = 2'd0;
    case (bytee_q)
      4'b0010: slot_idx = 2'd1;
      4'b0100: slot_idx = 2'd2;
      4'b1000: slot_idx = 2'd3;
      default: slot_idx = 2'd0;
    endcase
  end

  // Frame value, stability tracking and publish decision evaluated during CHECK.
  always_comb begin
    low_val   = 7'(slot_q[1]) * 7'd10 + 7'(slot_q[0]);
    high_val  = 7'(slot_q[3]) * 7'd10 + 7'(slot_q[2]);
    frame_val = {high_val[5:0], low_val[5:0]};
    frame_bad = (low_val > 7'd63) || (high_val > 7'd63);
    frame_eq  = (frame_val == last_q);
    match_inc = (match_q >= MATCH_MAX) ? MATCH_MAX : match_q + 1'b1;
    match_new = frame_eq ? match_inc : MW'(1);
    publish   = (match_new == MATCH_MAX) &&
                ((frame_val != data_out_q) || !data_stable_q);
    tcnt_inc    = (tcnt_q == TCNT_MAX) ? TCNT_MAX : tcnt_q + 1'b1;
    timeout_hit = (tcnt_inc == TCNT_MAX);
  end

  // Input capture, slot collection, frame check and error tracking in one state machine.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      bytee_q       <= '0;
      seg_q         <= '0;
      slot_q        <= '0;
      seen_q        <= '0;
      match_q       <= '0;
      tcnt_q        <= '0;
      last_q        <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      data_stable_q <= 1'b0;
      err_pattern_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;

      // The input register is frozen during CHECK so its contents are processed afterwards.
      if (state_q != CHECK) begin
        bytee_q <= bus.bytee_in;
        seg_q   <= bus.segment_in;
      end

      case (state_q)
        IDLE, COLLECT: begin
          if (bytee_q == 4'd0) begin
            tcnt_q <= tcnt_inc;
            if (timeout_hit) begin
              err_timeout_q <= 1'b1;
              data_stable_q <= 1'b0;
              seen_q        <= '0;
              match_q       <= '0;
              state_q       <= IDLE;
            end
          end else begin
            // Multi-hot enables are still bus activity, so they also restart the timeout.
            tcnt_q <= '0;
            if (onehot && glyph_ok) begin
              slot_q[slot_idx] <= glyph_digit;
              seen_q           <= seen_set;
              state_q          <= (seen_set == 4'hF) ? CHECK : COLLECT;
            end else begin
              err_pattern_q <= 1'b1;
              seen_q        <= '0;
              match_q       <= '0;
              data_stable_q <= 1'b0;
              state_q       <= COLLECT;
            end
          end
        end

        CHECK: begin
          seen_q  <= '0;
          state_q <= COLLECT;
          if (frame_bad) begin
            err_pattern_q <= 1'b1;
            match_q       <= '0;
            data_stable_q <= 1'b0;
          end else begin
            match_q <= match_new;
            if (!frame_eq) begin
              last_q        <= frame_val;
              data_stable_q <= 1'b0;
            end
            // Publishing wins over the drop so a one-frame threshold still reports stable.
            if (publish) begin
              data_out_q    <= frame_val;
              data_valid_q  <= 1'b1;
              data_stable_q <= 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.data_stable = data_stable_q;
  assign bus.err_pattern = err_pattern_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_segment_capture.sv
// Directed bench for segment_capture: active-high and active-low segment builds side by side.
// Latency: checks the 3-cycle pin-to-data_valid path on publishing frames.
// Backpressure: none; each digit is held one cycle followed by two blank cycles.
module tb_segment_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] bytee;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  segment_capture_if if_a ();
  segment_capture_if if_b ();

  assign if_a.bytee_in   = bytee;
  assign if_a.segment_in = seg;
  assign if_b.bytee_in   = bytee;
  assign if_b.segment_in = ~seg;

  segment_capture #(
    .STABLE_FRAMES (2),
    .TIMEOUT_CYCLES(64),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clock(clk),
    .reset(reset),
    .bus  (if_a)
  );

  segment_capture #(
    .STABLE_FRAMES (2),
    .TIMEOUT_CYCLES(64),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clock(clk),
    .reset(reset),
    .bus  (if_b)
  );

  always #5 clk = ~clk;

  // Count data_valid pulses of the active-high build, sampled mid-cycle.
  always @(negedge clk) begin
    if (if_a.data_valid === 1'b1) pulses++;
  end

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'h3F;
      1: glyph = 7'h06;
      2: glyph = 7'h5B;
      3: glyph = 7'h4F;
      4: glyph = 7'h66;
      5: glyph = 7'h6D;
      6: glyph = 7'h7D;
      7: glyph = 7'h07;
      8: glyph = 7'h7F;
      9: glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_digit(input int idx, input logic [6:0] g);
    bytee = 4'(1 << idx);
    seg   = g;
    tick(1);
    bytee = 4'd0;
    seg   = 7'd0;
    tick(2);
  endtask

  // Scan order: low ones, low tens, high ones, high tens.
  task automatic scan(input int high, input int low);
    put_digit(0, glyph(low % 10));
    put_digit(1, glyph(low / 10));
    put_digit(2, glyph(high % 10));
    put_digit(3, glyph(high / 10));
  endtask

  initial begin
    logic [11:0] v1234;
    logic [11:0] v1235;
    v1234 = {6'd12, 6'd34};
    v1235 = {6'd12, 6'd35};
    bytee = 4'd0;
    seg   = 7'd0;
    reset = 1'b0;
    tick(2);
    check("reset_data_out",    32'(if_a.data_out),    32'h0);
    check("reset_data_valid",  32'(if_a.data_valid),  32'h0);
    check("reset_data_stable", 32'(if_a.data_stable), 32'h0);
    check("reset_err_pattern", 32'(if_a.err_pattern), 32'h0);
    check("reset_err_timeout", 32'(if_a.err_timeout), 32'h0);
    reset = 1'b1;
    tick(1);

    // Two identical 12:34 frames publish once, three cycles after the last digit.
    scan(12, 34);
    tick(1);
    check("f1_no_pulse", 32'(pulses), 32'd0);
    check("f1_not_stable", 32'(if_a.data_stable), 32'h0);
    scan(12, 34);
    check("f2_valid_latency", 32'(if_a.data_valid), 32'h1);
    check("f2_data_out", 32'(if_a.data_out), 32'(v1234));
    tick(1);
    check("f2_valid_single", 32'(if_a.data_valid), 32'h0);
    check("f2_pulse_count", 32'(pulses), 32'd1);
    check("f2_stable", 32'(if_a.data_stable), 32'h1);

    // Repeat frame does not re-pulse; a new value drops stable, then republishes.
    scan(12, 34);
    tick(1);
    check("repeat_no_pulse", 32'(pulses), 32'd1);
    scan(12, 35);
    tick(1);
    check("chg_stable_drop", 32'(if_a.data_stable), 32'h0);
    check("chg_hold_out", 32'(if_a.data_out), 32'(v1234));
    check("chg_no_pulse", 32'(pulses), 32'd1);
    scan(12, 35);
    check("chg_valid", 32'(if_a.data_valid), 32'h1);
    check("chg_data_out", 32'(if_a.data_out), 32'h323);
    tick(1);
    check("chg_pulse_count", 32'(pulses), 32'd2);
    check("chg_stable", 32'(if_a.data_stable), 32'h1);
    check("pre_err_pattern", 32'(if_a.err_pattern), 32'h0);

    // Low value 69 is out of range.
    scan(12, 69);
    tick(1);
    check("ovr_err_pattern", 32'(if_a.err_pattern), 32'h1);
    check("ovr_stable", 32'(if_a.data_stable), 32'h0);
    check("ovr_data_out", 32'(if_a.data_out), 32'(v1235));
    check("ovr_no_pulse", 32'(pulses), 32'd2);
    check("ovr_no_timeout", 32'(if_a.err_timeout), 32'h0);
    scan(12, 35);
    scan(12, 35);
    tick(1);
    check("ovr_republish", 32'(pulses), 32'd3);
    check("ovr_restable", 32'(if_a.data_stable), 32'h1);

    // Blank bus: no timeout before the limit, timeout after it.
    tick(40);
    check("to_early", 32'(if_a.err_timeout), 32'h0);
    tick(40);
    check("to_err_timeout", 32'(if_a.err_timeout), 32'h1);
    check("to_stable", 32'(if_a.data_stable), 32'h0);
    check("to_data_out", 32'(if_a.data_out), 32'(v1235));
    scan(12, 35);
    tick(1);
    check("to_resume_f1", 32'(pulses), 32'd3);
    scan(12, 35);
    tick(1);
    check("to_resume_f2", 32'(pulses), 32'd4);
    check("to_resume_stable", 32'(if_a.data_stable), 32'h1);

    // Reset in the middle of a frame clears everything.
    put_digit(0, glyph(4));
    put_digit(1, glyph(3));
    reset = 1'b0;
    tick(1);
    check("mid_rst_data_out", 32'(if_a.data_out), 32'h0);
    check("mid_rst_stable", 32'(if_a.data_stable), 32'h0);
    check("mid_rst_err_pattern", 32'(if_a.err_pattern), 32'h0);
    check("mid_rst_err_timeout", 32'(if_a.err_timeout), 32'h0);
    reset = 1'b1;
    tick(1);
    repeat (3) begin
      put_digit(0, glyph(4));
      put_digit(1, glyph(3));
      put_digit(2, glyph(2));
    end
    tick(1);
    check("partial_no_pulse", 32'(pulses), 32'd4);
    check("partial_data_out", 32'(if_a.data_out), 32'h0);

    // Illegal low-tens glyph after a fresh publish.
    scan(12, 34);
    scan(12, 34);
    tick(1);
    check("pre_ill_pulse", 32'(pulses), 32'd5);
    put_digit(0, glyph(4));
    put_digit(1, 7'h49);
    tick(1);
    check("ill_err_pattern", 32'(if_a.err_pattern), 32'h1);
    check("ill_stable", 32'(if_a.data_stable), 32'h0);
    check("ill_no_pulse", 32'(pulses), 32'd5);
    check("ill_data_out", 32'(if_a.data_out), 32'(v1234));
    scan(12, 34);
    scan(12, 34);
    tick(1);
    check("ill_republish", 32'(pulses), 32'd6);
    check("ill_restable", 32'(if_a.data_stable), 32'h1);

    // Active-low build saw the inverted copy of the same scan.
    check("inv_data_out", 32'(if_b.data_out), 32'(v1234));
    check("inv_stable", 32'(if_b.data_stable), 32'h1);
    check("inv_err_pattern", 32'(if_b.err_pattern), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
